// File: rtl/mistral_m10k_fifo_ctrl_pkg.sv
// Shared types for the M10K-backed FIFO controller: output-buffer state
// encoding, buffer depth and a helper mapping state to word count.
package mistral_fifo_pkg;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_ONE   = 2'd1,
    OUT_TWO   = 2'd2
  } out_state_t;

  localparam int unsigned OUT_BUF_DEPTH = 32'd2;

  function automatic logic [1:0] entries_of(input out_state_t st);
    case (st)
      OUT_EMPTY: entries_of = 2'd0;
      OUT_ONE:   entries_of = 2'd1;
      OUT_TWO:   entries_of = 2'd2;
      default:   entries_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mistral_m10k_fifo_ctrl_if.sv
// Read-side valid/ready stream between the output buffer and its consumer.
interface mistral_m10k_fifo_ctrl_if #(
  parameter int DBITS = 10
);
  logic [DBITS-1:0] rdata;
  logic             rvalid;
  logic             rready;

  modport master (output rdata, output rvalid, input rready);
  modport slave  (input rdata, input rvalid, output rready);
endinterface

// File: rtl/mistral_m10k_fifo_ctrl_skid.sv
// Two-entry output buffer that absorbs the one-cycle RAM read latency and
// tells the pointer logic whether another read may be issued.
module mistral_fifo_skid
  import mistral_fifo_pkg::*;
#(
  parameter int DBITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DBITS-1:0]      b1_data,
  input  logic                  rd_issue,
  output logic                  rd_room,
  output logic [1:0]            entries,
  output logic                  pend,
  mistral_m10k_fifo_ctrl_if.master out_if
);

  localparam logic [2:0] BUF_DEPTH = 3'(OUT_BUF_DEPTH);

  out_state_t       state_q, state_d;
  logic             pend_q, pend_d;
  logic [DBITS-1:0] head_q, head_d;
  logic [DBITS-1:0] tail_q, tail_d;
  logic             pop;
  logic             capture;
  logic [2:0]       fill_after_pop;

  assign entries       = entries_of(state_q);
  assign pend          = pend_q;
  assign capture       = pend_q;
  assign out_if.rvalid = (state_q != OUT_EMPTY);
  assign out_if.rdata  = head_q;
  assign pop           = out_if.rvalid & out_if.rready;

  // Words held or already on their way, once this cycle's pop is taken out.
  assign fill_after_pop = {1'b0, entries} + {2'b00, pend_q} - {2'b00, pop};
  assign rd_room        = (fill_after_pop < BUF_DEPTH);

  // Next-state: buffer occupancy transitions and data movement.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pend_d  = rd_issue;
    case (state_q)
      OUT_EMPTY: begin
        if (capture) begin
          state_d = OUT_ONE;
          head_d  = b1_data;
        end else begin
          state_d = OUT_EMPTY;
        end
      end
      OUT_ONE: begin
        if (capture && pop) begin
          head_d = b1_data;
        end else if (capture) begin
          state_d = OUT_TWO;
          tail_d  = b1_data;
        end else if (pop) begin
          state_d = OUT_EMPTY;
        end else begin
          state_d = OUT_ONE;
        end
      end
      OUT_TWO: begin
        if (pop) begin
          state_d = OUT_ONE;
          head_d  = tail_q;
        end else begin
          state_d = OUT_TWO;
        end
      end
      default: begin
        state_d = OUT_EMPTY;
      end
    endcase
  end

  // Buffer state register; reset drops any word still in flight from the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      pend_q  <= 1'b0;
      head_q  <= {DBITS{1'b0}};
      tail_q  <= {DBITS{1'b0}};
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/mistral_m10k_fifo_ctrl.sv
// FIFO controller in front of a simple dual-port M10K: write/read pointers
// and RAM port drive here, read-latency buffering in mistral_fifo_skid.
module mistral_m10k_fifo_ctrl
  import mistral_fifo_pkg::*;
#(
  parameter int CFG_ABITS = 10,
  parameter int CFG_DBITS = 10
) (
  input  logic                 CLK1,
  input  logic                 ARESETN,
  input  logic [CFG_DBITS-1:0] WDATA,
  input  logic                 WVALID,
  output logic                 WREADY,
  output logic [CFG_DBITS-1:0] RDATA,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic [CFG_ABITS+1:0] COUNT,
  output logic [CFG_ABITS-1:0] A1ADDR,
  output logic [CFG_DBITS-1:0] A1DATA,
  output logic                 A1EN,
  output logic [CFG_ABITS-1:0] B1ADDR,
  output logic                 B1EN,
  input  logic [CFG_DBITS-1:0] B1DATA
);

  localparam int PW = CFG_ABITS + 1;
  localparam logic [PW-1:0] FULL_OCC = {1'b1, {CFG_ABITS{1'b0}}};
  localparam logic [PW-1:0] PTR_ONE  = {{CFG_ABITS{1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] occ;
  logic          push;
  logic          rd_issue;
  logic          rd_room;
  logic          pend;
  logic [1:0]    entries;

  mistral_m10k_fifo_ctrl_if #(.DBITS(CFG_DBITS)) rd_if ();

  mistral_fifo_skid #(.DBITS(CFG_DBITS)) u_skid (
    .clk      (CLK1),
    .rst_n    (ARESETN),
    .b1_data  (B1DATA),
    .rd_issue (rd_issue),
    .rd_room  (rd_room),
    .entries  (entries),
    .pend     (pend),
    .out_if   (rd_if.master)
  );

  assign rd_if.rready = RREADY;
  assign RDATA        = rd_if.rdata;
  assign RVALID       = rd_if.rvalid;

  // occ counts committed writes only, so a word is never read in its write cycle.
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign WREADY   = (occ != FULL_OCC) & ARESETN;
  assign push     = WVALID & WREADY;
  assign rd_issue = (occ != {PW{1'b0}}) & rd_room;

  assign COUNT = {1'b0, occ}
               + {{(CFG_ABITS+1){1'b0}}, pend}
               + {{CFG_ABITS{1'b0}}, entries};

  // RAM port drive and pointer advance.
  always_comb begin
    A1EN   = push;
    A1ADDR = wr_ptr_q[CFG_ABITS-1:0];
    A1DATA = WDATA;
    B1EN   = rd_issue;
    B1ADDR = rd_ptr_q[CFG_ABITS-1:0];
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; wrap is plain modular overflow.
  always_ff @(posedge CLK1 or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_mistral_m10k_fifo_ctrl.sv
// Directed bench for mistral_m10k_fifo_ctrl with a behavioural M10K model
// and a queue scoreboard of pushed words.
module tb_mistral_m10k_fifo_ctrl;

  localparam int AB    = 10;
  localparam int DB    = 10;
  localparam int DEPTH = 1 << AB;

  logic          CLK1;
  logic          ARESETN;
  logic [DB-1:0] WDATA;
  logic          WVALID;
  logic          WREADY;
  logic [AB+1:0] COUNT;
  logic [AB-1:0] A1ADDR;
  logic [DB-1:0] A1DATA;
  logic          A1EN;
  logic [AB-1:0] B1ADDR;
  logic          B1EN;
  logic [DB-1:0] B1DATA;

  mistral_m10k_fifo_ctrl_if #(.DBITS(DB)) rif ();

  mistral_m10k_fifo_ctrl #(.CFG_ABITS(AB), .CFG_DBITS(DB)) dut (
    .CLK1    (CLK1),
    .ARESETN (ARESETN),
    .WDATA   (WDATA),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .RDATA   (rif.rdata),
    .RVALID  (rif.rvalid),
    .RREADY  (rif.rready),
    .COUNT   (COUNT),
    .A1ADDR  (A1ADDR),
    .A1DATA  (A1DATA),
    .A1EN    (A1EN),
    .B1ADDR  (B1ADDR),
    .B1EN    (B1EN),
    .B1DATA  (B1DATA)
  );

  initial CLK1 = 1'b0;
  always #5 CLK1 = ~CLK1;

  logic [DB-1:0] mem [0:DEPTH-1];
  always @(posedge CLK1) begin
    if (A1EN) mem[A1ADDR] <= A1DATA;
    if (B1EN) B1DATA <= mem[B1ADDR];
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [DB-1:0] sb [$];
  int n_push, n_pop, n_iss, wr_idx, rd_idx;
  logic hold_v;
  logic [DB-1:0] hold_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    sb.delete();
    n_push = 0; n_pop = 0; n_iss = 0; wr_idx = 0; rd_idx = 0;
    hold_v = 1'b0; hold_d = '0;
  endtask

  // Called mid-cycle: checks this cycle's handshakes and updates the scoreboard.
  task automatic monitor();
    int   occ_m;
    int   inflight;
    logic pop_m;
    occ_m    = n_push - n_iss;
    inflight = n_iss - n_pop;
    pop_m    = rif.rvalid & rif.rready;
    chk("count", 32'(COUNT), n_push - n_pop);
    chk("wready", 32'(WREADY), 32'(ARESETN && (occ_m != DEPTH)));
    chk("a1en", 32'(A1EN), 32'(WVALID & WREADY));
    if (hold_v) begin
      chk("hold_rvalid", 32'(rif.rvalid), 32'd1);
      chk("hold_rdata", 32'(rif.rdata), 32'(hold_d));
    end
    if (B1EN) begin
      chk("b1_addr", 32'(B1ADDR), rd_idx % DEPTH);
      chk("b1_room", 32'((inflight + 1 - int'(pop_m)) <= 2), 32'd1);
      chk("b1_nonempty", 32'(occ_m > 0), 32'd1);
      if (A1EN) chk("b1_not_a1", 32'(B1ADDR != A1ADDR), 32'd1);
      n_iss++; rd_idx++;
    end
    if (A1EN) begin
      chk("a1_addr", 32'(A1ADDR), wr_idx % DEPTH);
      chk("a1_data", 32'(A1DATA), 32'(WDATA));
      sb.push_back(WDATA);
      n_push++; wr_idx++;
    end
    if (pop_m) begin
      chk("pop_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("rdata", 32'(rif.rdata), 32'(sb.pop_front()));
      n_pop++;
    end
    hold_v = rif.rvalid & ~rif.rready;
    hold_d = rif.rdata;
  endtask

  // One clock: inputs set at posedge+1, checked at negedge, returns at posedge+1.
  task automatic cyc();
    @(negedge CLK1);
    monitor();
    @(posedge CLK1);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int bubbles;
    int guard;
    int n;
    int stale;

    ARESETN = 1'b0; WVALID = 1'b0; WDATA = '0; rif.rready = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK1);
    #1;
    WVALID = 1'b1;
    #1;
    chk("reset_rvalid", 32'(rif.rvalid), 32'd0);
    chk("reset_wready", 32'(WREADY), 32'd0);
    chk("reset_count", 32'(COUNT), 32'd0);
    chk("reset_a1en", 32'(A1EN), 32'd0);
    chk("reset_b1en", 32'(B1EN), 32'd0);
    WVALID = 1'b0;
    @(negedge CLK1);
    ARESETN = 1'b1;
    @(posedge CLK1);
    #1;
    chk("wready_after_reset", 32'(WREADY), 32'd1);

    // Single word latency
    WDATA = 10'h155; WVALID = 1'b1; rif.rready = 1'b1;
    cyc();
    WVALID = 1'b0;
    chk("t1_b1en_e0", 32'(B1EN), 32'd1);
    chk("t1_rvalid_e0", 32'(rif.rvalid), 32'd0);
    cyc();
    chk("t1_rvalid_e1", 32'(rif.rvalid), 32'd0);
    cyc();
    chk("t1_rvalid_e2", 32'(rif.rvalid), 32'd1);
    chk("t1_rdata_e2", 32'(rif.rdata), 32'h155);
    cyc();
    chk("t1_count_after", 32'(COUNT), 32'd0);
    chk("t1_rvalid_after", 32'(rif.rvalid), 32'd0);

    // Streaming push/pop, four pointer wraps
    bubbles = 0;
    for (int i = 0; i < 4096; i++) begin
      WDATA = DB'(i); WVALID = 1'b1;
      cyc();
      if (i >= 2 && !rif.rvalid) bubbles++;
      if (!WREADY) bubbles++;
    end
    WVALID = 1'b0;
    chk("stream_bubbles", bubbles, 32'd0);
    guard = 0;
    while (COUNT != 0 && guard < 50) begin cyc(); guard++; end
    chk("stream_drained", 32'(COUNT), 32'd0);
    chk("stream_pops", n_pop, 32'd4097);

    // Fill with consumer stalled
    rif.rready = 1'b0; WVALID = 1'b1; n = 0; guard = 0;
    while (WREADY && guard < 1100) begin
      WDATA = DB'(n * 3 + 7);
      cyc();
      n++; guard++;
    end
    chk("fill_pushes", n, 32'd1026);
    chk("fill_count", 32'(COUNT), 32'd1026);
    chk("fill_wready", 32'(WREADY), 32'd0);
    chk("fill_a1en", 32'(A1EN), 32'd0);
    WDATA = 10'h3C3;
    cyc();
    chk("fill_refused_count", 32'(COUNT), 32'd1026);

    // Full: simultaneous push and pop refuses the push this cycle
    rif.rready = 1'b1;
    #1;
    chk("full_pop_a1en", 32'(A1EN), 32'd0);
    cyc();
    chk("full_next_wready", 32'(WREADY), 32'd1);
    chk("full_next_a1en", 32'(A1EN), 32'd1);
    rif.rready = 1'b0;
    cyc();
    WVALID = 1'b0;

    // Drain under random consumer stalls
    guard = 0;
    while ((sb.size() != 0 || COUNT != 0) && guard < 6000) begin
      rif.rready = 1'($urandom_range(0, 1));
      cyc();
      guard++;
    end
    chk("drain_count", 32'(COUNT), 32'd0);
    chk("drain_sb_empty", sb.size(), 32'd0);

    // Reset while a read is in flight
    rif.rready = 1'b0; WVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      WDATA = DB'(10'h300 + i);
      cyc();
    end
    chk("pre_rst_count", 32'(COUNT), 32'd3);
    chk("pre_rst_rvalid", 32'(rif.rvalid), 32'd1);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rif.rvalid), 32'd0);
    chk("mid_rst_wready", 32'(WREADY), 32'd0);
    chk("mid_rst_count", 32'(COUNT), 32'd0);
    chk("mid_rst_a1en", 32'(A1EN), 32'd0);
    chk("mid_rst_b1en", 32'(B1EN), 32'd0);
    model_clear();
    cyc();
    cyc();
    WVALID = 1'b0; rif.rready = 1'b1;
    #2;
    ARESETN = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (rif.rvalid) stale++;
    end
    chk("post_rst_stale", stale, 32'd0);
    chk("post_rst_count", 32'(COUNT), 32'd0);
    WDATA = 10'h2AA; WVALID = 1'b1;
    cyc();
    WVALID = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin cyc(); guard++; end
    chk("post_rst_pops", n_pop, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
